flash_adc_conv_ctrl: RTL and testbench

Conversion sequencer for the flash ADC comparator bank. On a START request it waits a programmable settle time, samples the thermometer-coded COMP bus over 2^LOG2_NSAMP consecutive cycles, and decodes each sample to binary. It then averages the decoded samples and presents the result on a valid/ready handshake. It sits between the comparator bank and the downstream consumer, and owns all timing of the conversion.

---
 rtl/flash_adc_pkg.sv | 26 ++
 rtl/flash_adc_therm_decode.sv | 39 +++
 rtl/flash_adc_conv_ctrl.sv | 148 ++++++++++++++
 tb/tb_flash_adc_conv_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/flash_adc_pkg.sv
// Shared types and default constants for the flash ADC conversion sequencer.
// The bubble check is included when FLASH_ADC_BUBBLE_CHECK_EN is defined.
package flash_adc_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Default configuration
  localparam int DEF_COMP_W     = 4;
  localparam int DEF_B_W        = 2;
  localparam int DEF_LOG2_NSAMP = 2;
  localparam int DEF_SETTLE_CYC = 2;

  // The accumulator holds 2^log2_nsamp codes of at most 2^b_w-1, so it never overflows
  function automatic int acc_width(input int b_w, input int log2_nsamp);
    return b_w + log2_nsamp;
  endfunction

  localparam int DEF_ACC_W = acc_width(DEF_B_W, DEF_LOG2_NSAMP);

endpackage

// File: rtl/flash_adc_therm_decode.sv
// Combinational thermometer decoder: saturated popcount plus bubble detect.
// The bubble output is consumed only when FLASH_ADC_BUBBLE_CHECK_EN is defined.
module flash_adc_therm_decode
  import flash_adc_pkg::*;
#(
  parameter int COMP_W = DEF_COMP_W,
  parameter int B_W    = DEF_B_W
) (
  input  logic [COMP_W-1:0] comp,
  output logic [B_W-1:0]    code,
  output logic              bubble
);

  localparam int unsigned CODE_MAX = (1 << B_W) - 1;

  logic [COMP_W-1:0] comp_plus1;

  // Count ones and clamp to the largest representable code
  always_comb begin
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < COMP_W; i++) begin
      ones = ones + 32'(comp[i]);
    end
    if (ones > CODE_MAX) begin
      code = B_W'(CODE_MAX);
    end else begin
      code = B_W'(ones);
    end
  end

  // A valid thermometer word 0..01..1 plus one is a power of two (or wraps to 0),
  // so it shares no set bits with the original word
  always_comb begin
    comp_plus1 = comp + COMP_W'(1);
    bubble     = |(comp & comp_plus1);
  end

endmodule

// File: rtl/flash_adc_conv_ctrl.sv
// Flash ADC conversion sequencer: settle, sample 2^LOG2_NSAMP codes, average,
// then hold the result on a valid/ready handshake until accepted.
// Optional bubble checking is enabled by FLASH_ADC_BUBBLE_CHECK_EN.
module flash_adc_conv_ctrl
  import flash_adc_pkg::*;
#(
  parameter int COMP_W     = DEF_COMP_W,
  parameter int B_W        = DEF_B_W,
  parameter int LOG2_NSAMP = DEF_LOG2_NSAMP,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [COMP_W-1:0] comp,
  input  logic              ready,
  output logic              busy,
  output logic              valid,
  output logic [B_W-1:0]    b,
  output logic              err
);

  localparam int ACC_W = acc_width(B_W, LOG2_NSAMP);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int SMP_W = (LOG2_NSAMP > 0) ? LOG2_NSAMP : 1;

  localparam logic [SET_W-1:0] SET_INIT = (SETTLE_CYC > 0) ? SET_W'(SETTLE_CYC - 1) : '0;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << LOG2_NSAMP) - 1);

  state_t           state_reg;
  logic [SET_W-1:0] set_cnt_reg;
  logic [SMP_W-1:0] smp_cnt_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic             busy_reg;
  logic             valid_reg;
  logic [B_W-1:0]   b_reg;
  logic [B_W-1:0]   dec_code;

`ifdef FLASH_ADC_BUBBLE_CHECK_EN
  logic             dec_bubble;
  logic             bubble_seen_reg;
  logic             err_reg;
`else
  logic             dec_bubble_unused;
`endif

  flash_adc_therm_decode #(
    .COMP_W (COMP_W),
    .B_W    (B_W)
  ) u_decode (
    .comp   (comp),
    .code   (dec_code),
`ifdef FLASH_ADC_BUBBLE_CHECK_EN
    .bubble (dec_bubble)
`else
    .bubble (dec_bubble_unused)
`endif
  );

  // Running sum including the sample taken on this edge
  always_comb begin
    acc_next = acc_reg + ACC_W'(dec_code);
  end

  // Conversion sequencer with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      set_cnt_reg     <= '0;
      smp_cnt_reg     <= '0;
      acc_reg         <= '0;
      busy_reg        <= 1'b0;
      valid_reg       <= 1'b0;
      b_reg           <= '0;
`ifdef FLASH_ADC_BUBBLE_CHECK_EN
      bubble_seen_reg <= 1'b0;
      err_reg         <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg         <= '0;
            smp_cnt_reg     <= '0;
            busy_reg        <= 1'b1;
`ifdef FLASH_ADC_BUBBLE_CHECK_EN
            bubble_seen_reg <= 1'b0;
`endif
            if (SETTLE_CYC == 0) begin
              state_reg <= SAMPLE;
            end else begin
              state_reg   <= SETTLE;
              set_cnt_reg <= SET_INIT;
            end
          end
        end
        SETTLE: begin
          if (set_cnt_reg == '0) begin
            state_reg   <= SAMPLE;
            smp_cnt_reg <= '0;
          end else begin
            set_cnt_reg <= set_cnt_reg - SET_W'(1);
          end
        end
        SAMPLE: begin
          acc_reg <= acc_next;
`ifdef FLASH_ADC_BUBBLE_CHECK_EN
          bubble_seen_reg <= bubble_seen_reg | dec_bubble;
`endif
          if (smp_cnt_reg == SMP_LAST) begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
            b_reg     <= B_W'(acc_next >> LOG2_NSAMP);
`ifdef FLASH_ADC_BUBBLE_CHECK_EN
            err_reg   <= bubble_seen_reg | dec_bubble;
`endif
          end else begin
            smp_cnt_reg <= smp_cnt_reg + SMP_W'(1);
          end
        end
        DONE: begin
          // START here is deliberately dropped; a new request is only taken from IDLE
          if (ready) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign valid = valid_reg;
  assign b     = b_reg;
`ifdef FLASH_ADC_BUBBLE_CHECK_EN
  assign err   = err_reg;
`else
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_flash_adc_conv_ctrl.sv
// Directed self-checking bench for flash_adc_conv_ctrl at default parameters.
// Expected ERR follows whether FLASH_ADC_BUBBLE_CHECK_EN is defined.
module tb_flash_adc_conv_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] comp;
  logic       ready;
  logic       busy;
  logic       valid;
  logic [1:0] b;
  logic       err;

  int chk_count;
  int err_count;

`ifdef FLASH_ADC_BUBBLE_CHECK_EN
  localparam logic BUBBLE_ERR = 1'b1;
`else
  localparam logic BUBBLE_ERR = 1'b0;
`endif

  flash_adc_conv_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .comp  (comp),
    .ready (ready),
    .busy  (busy),
    .valid (valid),
    .b     (b),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    chk_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  8'(busy),  8'd0);
    check({tag, "_valid"}, 8'(valid), 8'd0);
    check({tag, "_b"},     8'(b),     8'd0);
    check({tag, "_err"},   8'(err),   8'd0);
  endtask

  // Start a conversion and feed c0..c3 on the four sample edges (t+3..t+6);
  // returns just after edge t+6 with the result checked
  task automatic do_conv(input string tag, input logic [3:0] c0, input logic [3:0] c1,
                         input logic [3:0] c2, input logic [3:0] c3,
                         input logic [1:0] exp_b, input logic exp_err);
    start = 1'b1;
    comp  = c0;
    tick();                               // edge t: accept
    start = 1'b0;
    check({tag, "_busy_rise"}, 8'(busy), 8'd1);
    tick();                               // t+1
    tick();                               // t+2
    tick();                               // t+3: sample c0
    comp = c1;
    tick();                               // t+4: sample c1
    comp = c2;
    tick();                               // t+5: sample c2
    check({tag, "_valid_early"}, 8'(valid), 8'd0);
    comp = c3;
    tick();                               // t+6: sample c3
    check({tag, "_valid"}, 8'(valid), 8'd1);
    check({tag, "_b"},     8'(b),     8'(exp_b));
    check({tag, "_err"},   8'(err),   8'(exp_err));
    $display("conv %s: comp %b %b %b %b -> b=%b err=%b (exp b=%b err=%b)",
             tag, c0, c1, c2, c3, b, err, exp_b, exp_err);
  endtask

  initial begin
    chk_count = 0;
    err_count = 0;
    rst   = 1'b1;
    start = 1'b0;
    comp  = 4'b0000;
    ready = 1'b0;

    // 1: reset with random inputs, START ignored
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      comp  = 4'($urandom_range(0, 15));
      ready = 1'($urandom_range(0, 1));
      tick();
      check_idle_outputs("rst");
    end
    start = 1'b0;
    rst   = 1'b0;
    ready = 1'b1;
    tick();
    check_idle_outputs("post_rst");
    $display("reset: busy=%b valid=%b b=%b err=%b", busy, valid, b, err);

    // 2: constant 0111, immediate acceptance
    do_conv("t2", 4'b0111, 4'b0111, 4'b0111, 4'b0111, 2'b11, 1'b0);
    tick();
    check("t2_valid_fall", 8'(valid), 8'd0);
    check("t2_busy_fall",  8'(busy),  8'd0);

    // 3: varying comp, sum 8 -> 2
    do_conv("t3", 4'b0001, 4'b0011, 4'b0011, 4'b0111, 2'b10, 1'b0);
    tick();

    // 4: one bubble sample, then full-scale saturation
    do_conv("t4_bub", 4'b0011, 4'b0101, 4'b0011, 4'b0011, 2'b10, BUBBLE_ERR);
    tick();
    do_conv("t4_sat", 4'b1111, 4'b1111, 4'b1111, 4'b1111, 2'b11, 1'b0);
    tick();
    check("t4_err_cleared_idle", 8'(valid), 8'd0);

    // 5: stall with READY low, START pulses in DONE and on the accept edge are dropped
    ready = 1'b0;
    do_conv("t5", 4'b0101, 4'b0001, 4'b0001, 4'b0001, 2'b01, BUBBLE_ERR);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      check("t5_hold_valid", 8'(valid), 8'd1);
      check("t5_hold_b",     8'(b),     8'd1);
      check("t5_hold_err",   8'(err),   8'(BUBBLE_ERR));
    end
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_release_valid", 8'(valid), 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t5_no_restart_busy",  8'(busy),  8'd0);
      check("t5_no_restart_valid", 8'(valid), 8'd0);
    end
    $display("stall: held 5 cycles, released, no second conversion");

    // 6: asynchronous reset during the second sample cycle
    start = 1'b1;
    comp  = 4'b1111;
    tick();                               // t
    start = 1'b0;
    tick();                               // t+1
    tick();                               // t+2
    tick();                               // t+3: first sample taken
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("t6_abort");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t6_no_valid", 8'(valid), 8'd0);
    end
    $display("abort: reset mid-sample, no result emitted");
    do_conv("t6_fresh", 4'b0001, 4'b0001, 4'b0001, 4'b0001, 2'b01, 1'b0);
    tick();
    check("t6_valid_fall", 8'(valid), 8'd0);

    $display("CHECKS %0d ERRORS %0d", chk_count, err_count);
    $finish;
  end

endmodule
